// File: rtl/controlador_entrada_operandos.sv
// Keypad-entry controller: captures two NDIG-digit BCD operands and add/sub,
// runs a req/ack handshake with the arithmetic unit and shows the result.
//
// state   | meaning
// ENTER_A | shifting digits into operand A
// ENTER_B | shifting digits into operand B, operator chosen
// BUSY    | calc_req held, waiting for calc_ack
// SHOW    | result latched and displayed
module controlador_entrada_operandos #(
  parameter  int NDIG = 3,
  localparam int DW   = 4*NDIG,
  localparam int RW   = 4*(NDIG+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    key_value,
  input  logic          key_valid,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic          op_sub,
  output logic          calc_req,
  input  logic          calc_ack,
  input  logic [RW-1:0] res_digits,
  input  logic          res_neg,
  output logic [RW-1:0] disp_digits,
  output logic          disp_neg,
  output logic [1:0]    phase,
  output logic          ovf_key
);

  localparam int CW = $clog2(NDIG+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_BS  = 4'hD;
  localparam logic [3:0] KEY_ENT = 4'hE;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    BUSY    = 2'd2,
    SHOW    = 2'd3
  } phase_t;

  phase_t        phase_q, phase_d;
  logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic          op_sub_q, op_sub_d;
  logic          req_q, req_d;
  logic [RW-1:0] res_q, res_d;
  logic          res_neg_q, res_neg_d;
  logic          ovf_q, ovf_d;
  logic          is_digit;
  logic          do_clear;
  logic          load_first;

  assign is_digit = (key_value <= 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= ENTER_A;
      op_a_q    <= '0;
      op_b_q    <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      op_sub_q  <= 1'b0;
      req_q     <= 1'b0;
      res_q     <= '0;
      res_neg_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      op_sub_q  <= op_sub_d;
      req_q     <= req_d;
      res_q     <= res_d;
      res_neg_q <= res_neg_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    op_sub_d   = op_sub_q;
    req_d      = req_q;
    res_d      = res_q;
    res_neg_d  = res_neg_q;
    ovf_d      = 1'b0;
    do_clear   = 1'b0;
    load_first = 1'b0;

    case (phase_q)
      ENTER_A, ENTER_B: begin
        if (key_valid) begin
          if (is_digit) begin
            if (phase_q == ENTER_A) begin
              if (cnt_a_q != CNT_MAX) begin
                op_a_d  = (op_a_q << 4) | DW'(key_value);
                cnt_a_d = cnt_a_q + CW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              if (cnt_b_q != CNT_MAX) begin
                op_b_d  = (op_b_q << 4) | DW'(key_value);
                cnt_b_d = cnt_b_q + CW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end
          end else begin
            case (key_value)
              KEY_ADD, KEY_SUB: begin
                op_sub_d = (key_value == KEY_SUB);
                phase_d  = ENTER_B;
              end
              KEY_CLR: do_clear = 1'b1;
              KEY_BS: begin
                if (phase_q == ENTER_A) begin
                  if (cnt_a_q != '0) begin
                    op_a_d  = op_a_q >> 4;
                    cnt_a_d = cnt_a_q - CW'(1);
                  end
                end else if (cnt_b_q != '0) begin
                  op_b_d  = op_b_q >> 4;
                  cnt_b_d = cnt_b_q - CW'(1);
                end else begin
                  phase_d = ENTER_A;
                end
              end
              KEY_ENT: begin
                if (phase_q == ENTER_B) begin
                  phase_d = BUSY;
                  req_d   = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      BUSY: begin
        if (calc_ack) begin
          res_d     = res_digits;
          res_neg_d = res_neg;
          req_d     = 1'b0;
          phase_d   = SHOW;
        end
      end
      SHOW: begin
        if (key_valid) begin
          if (is_digit) begin
            do_clear   = 1'b1;
            load_first = 1'b1;
          end else if (key_value == KEY_CLR) begin
            do_clear = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (do_clear) begin
      phase_d   = ENTER_A;
      op_a_d    = '0;
      op_b_d    = '0;
      cnt_a_d   = '0;
      cnt_b_d   = '0;
      op_sub_d  = 1'b0;
      res_d     = '0;
      res_neg_d = 1'b0;
    end
    // a digit pressed while showing a result starts a fresh operand A
    if (load_first) begin
      op_a_d  = DW'(key_value);
      cnt_a_d = CW'(1);
    end
  end

  always_comb begin
    disp_digits = '0;
    disp_neg    = 1'b0;
    case (phase_q)
      ENTER_A:       disp_digits = RW'(op_a_q);
      ENTER_B, BUSY: disp_digits = RW'(op_b_q);
      SHOW: begin
        disp_digits = res_q;
        disp_neg    = res_neg_q;
      end
      default: ;
    endcase
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_sub   = op_sub_q;
  assign calc_req = req_q;
  assign phase    = phase_q;
  assign ovf_key  = ovf_q;

endmodule
